seq_sub64: RTL and testbench
============================

# seq_sub64

Multi-cycle 64-bit subtractor computing d = a − b − bin one 16-bit slice per clock, with the borrow held in a register between slices. It is the inverse-direction counterpart of the team's wide carry-lookahead adders: the same slice-and-carry decomposition, run as subtraction and time-multiplexed over a single slice. Operands enter through a valid/ready handshake and the result leaves through one. It sits in the datapath wherever area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 64, operand and result width; must be a multiple of SLICE.
- SLICE, 16, bits processed per RUN cycle; NSLICE = WIDTH/SLICE (4 by default).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset. **Synchronous, active-high.**
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; 1 only in IDLE and rst low.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- d  out  WIDTH  difference, a − b − bin mod 2^WIDTH.
- bout  out  1  borrow out; 1 iff a < b + bin (unsigned).
- zero, neg, ovf  out  1 each  result flags; present only with SEQ_SUB_FLAGS_EN.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at a clock edge: latch a and b, set carry=~bin, set idx=0, go to RUN.
- RUN, one slice per cycle:
  - {c, s} = a[idx] + ~b[idx] + carry.
  - Write d[idx]=s and carry=c.
  - When idx==NSLICE−1: set bout=~c, go to DONE. Otherwise idx++.
- DONE:
  - out_valid=1.
  - d, bout and flags are held stable.
  - When out_ready is high, go to IDLE.
- Behaviour outside IDLE:
  - No new operands are accepted.
  - a, b and bin are ignored except in the acceptance cycle.
  - in_valid pulses are dropped, not queued.
- d is written only slice by slice in RUN. Slices not yet computed hold the previous result until overwritten. Only the DONE value is meaningful.
- Reset (rst=1 at an edge), from any state including mid-RUN or DONE:
  - state=IDLE, idx=0, carry=0, d=0, bout=0, flags=0, out_valid=0.
  - The in-flight operation is discarded.
  - in_ready=0 while rst is high and 1 in the first cycle after release.

## Timing
- Acceptance happens at edge E0. RUN cycles follow at edges E1..E4, and out_valid=1 in the cycle after E4. Latency is NSLICE+1 = 5 cycles from acceptance to valid.
- If out_ready=1 in the first DONE cycle, the block is back in IDLE one cycle later. Minimum issue interval is NSLICE+2 = 6 cycles.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- The critical path is one SLICE-bit add plus the carry mux.

## Configuration
- SEQ_SUB_FLAGS_EN defined:
  - zero = (d==0), neg = d[WIDTH−1], ovf = (a[MSB]≠b[MSB]) && (d[MSB]≠a[MSB]).
  - Flags are registered on the RUN→DONE transition, valid with out_valid, and reset to 0.
  - bin is included in the d used for the flags.
- Undefined: zero, neg and ovf ports and their logic are absent; all other behaviour is identical.

## Structure
- Package sub_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - default WIDTH/SLICE constants;
  - a localparam function for NSLICE and the idx width, clog2(NSLICE), minimum 1.
- One sub-module, sub_slice: a combinational SLICE-bit a + ~b + cin, returning the sum and carry-out.
- Instantiate sub_slice once, with operand slices selected by idx.

## Test plan
- Basic subtract: a=0x10, b=0x3, bin=0 → d=0xD, bout=0, out_valid exactly 5 cycles after acceptance. With a=5, b=2, bin=1 → d=2.
- Underflow: a=0, b=1 → d=0xFFFF_FFFF_FFFF_FFFF, bout=1, neg=1, zero=0, ovf=0.
- Borrow across all slices: a=0x0001_0000_0000_0000, b=1 → d=0x0000_FFFF_FFFF_FFFF, bout=0.
- Flags: a=0x8000_0000_0000_0000, b=1 → d=0x7FFF_FFFF_FFFF_FFFF, ovf=1, neg=0. Then a=b=0x1234, bin=0 → zero=1.
- Backpressure: hold out_ready=0 for 10 DONE cycles while pulsing in_valid → d, bout and out_valid stable, in_ready=0, pulses ignored. Release → IDLE next cycle, and the next operation is correct.
- Reset during RUN at idx=2 → next cycle out_valid=0, d=0, bout=0, in_ready=1 after rst drops. A following a=7, b=3 gives d=4.

Source files
------------

// File: rtl/seq_sub64_pkg.sv
// Shared types and sizing helpers for the sequential slice subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice-index width; a single slice still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_sub64_if.sv
// Operand/result handshake bundle for seq_sub64.
// zero/neg/ovf exist only when SEQ_SUB_FLAGS_EN is defined.
interface seq_sub64_if
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SEQ_SUB_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
`ifdef SEQ_SUB_FLAGS_EN
    , input zero, neg, ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
`ifdef SEQ_SUB_FLAGS_EN
    , output zero, neg, ovf
`endif
  );
endinterface

// File: rtl/seq_sub64_slice.sv
// One SLICE-bit subtract step: a + ~b + cin, carry-out is the inverted borrow.
module sub_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);
  // Single adder; subtraction comes from inverting b and seeding cin.
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
  end
endmodule

// File: rtl/seq_sub64.sv
// Sequential d = a - b - bin, one SLICE per RUN cycle with the carry held in a register.
// Optional result flags (zero/neg/ovf) are built when SEQ_SUB_FLAGS_EN is defined.
module seq_sub64
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  seq_sub64_if.slave  bus
);
  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  sub_state_e       state_r;
  logic [IDXW-1:0]  idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             out_valid_r;
  logic             idle_r;
  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_b_s;
  logic [SLICE-1:0] sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] d_next_s;
`ifdef SEQ_SUB_FLAGS_EN
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;
`endif

  // Operand slice select and the result as it will look after this RUN cycle.
  always_comb begin
    slice_a_s = a_r[idx_r*SLICE +: SLICE];
    slice_b_s = b_r[idx_r*SLICE +: SLICE];
    d_next_s  = d_r;
    d_next_s[idx_r*SLICE +: SLICE] = sum_s;
  end

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Control FSM and datapath registers; handshake outputs come straight from state bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDXW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      idle_r      <= 1'b1;
`ifdef SEQ_SUB_FLAGS_EN
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= ~bus.bin;
            idx_r   <= {IDXW{1'b0}};
            idle_r  <= 1'b0;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          d_r     <= d_next_s;
          carry_r <= cout_s;
          if (idx_r == LAST_IDX) begin
            bout_r      <= ~cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef SEQ_SUB_FLAGS_EN
            // Flags see the final result including bin.
            zero_r <= (d_next_s == {WIDTH{1'b0}});
            neg_r  <= d_next_s[WIDTH-1];
            ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_next_s[WIDTH-1] != a_r[WIDTH-1]);
`endif
          end else begin
            idx_r <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            idle_r      <= 1'b1;
            idx_r       <= {IDXW{1'b0}};
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          idle_r      <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = idle_r & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;
`ifdef SEQ_SUB_FLAGS_EN
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_seq_sub64.sv
// Directed self-checking bench for seq_sub64; flag checks compile in with SEQ_SUB_FLAGS_EN.
module tb_seq_sub64;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_sub64_if #(.WIDTH(64)) bus ();

  seq_sub64 #(.WIDTH(64), .SLICE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; lat = edges from acceptance to out_valid, counting the acceptance edge.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                       output int lat, output logic timeout);
    int n;
    timeout = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) timeout = 1'b1;
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 64'h0; bus.b = 64'h0; bus.bin = 1'b0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) timeout = 1'b1;
    lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.d !== 64'h0) begin bad++; $display("FAIL reset_d got=%h exp=0", bus.d); end
    total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b exp=0", bus.bout); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic        vbin [6];
    logic [63:0] vd [6];
    logic        vbout [6];
    logic [2:0]  vflg [6];
    int lat;
    logic to;
    va[0]=64'h10;                  vb[0]=64'h3;    vbin[0]=1'b0; vd[0]=64'hD;                  vbout[0]=1'b0; vflg[0]=3'b000;
    va[1]=64'h5;                   vb[1]=64'h2;    vbin[1]=1'b1; vd[1]=64'h2;                  vbout[1]=1'b0; vflg[1]=3'b000;
    va[2]=64'h0;                   vb[2]=64'h1;    vbin[2]=1'b0; vd[2]=64'hFFFF_FFFF_FFFF_FFFF; vbout[2]=1'b1; vflg[2]=3'b010;
    va[3]=64'h0001_0000_0000_0000; vb[3]=64'h1;    vbin[3]=1'b0; vd[3]=64'h0000_FFFF_FFFF_FFFF; vbout[3]=1'b0; vflg[3]=3'b000;
    va[4]=64'h8000_0000_0000_0000; vb[4]=64'h1;    vbin[4]=1'b0; vd[4]=64'h7FFF_FFFF_FFFF_FFFF; vbout[4]=1'b0; vflg[4]=3'b001;
    va[5]=64'h1234;                vb[5]=64'h1234; vbin[5]=1'b0; vd[5]=64'h0;                  vbout[5]=1'b0; vflg[5]=3'b100;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vbin[i], lat, to);
      total++; if (to) begin bad++; $display("FAIL vec%0d_timeout got=timeout exp=valid", i); end
      total++; if (lat != 5) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=5", i, lat); end
      total++; if (bus.d !== vd[i]) begin bad++; $display("FAIL vec%0d_d got=%h exp=%h", i, bus.d, vd[i]); end
      total++; if (bus.bout !== vbout[i]) begin bad++; $display("FAIL vec%0d_bout got=%b exp=%b", i, bus.bout, vbout[i]); end
`ifdef SEQ_SUB_FLAGS_EN
      total++;
      if ({bus.zero, bus.neg, bus.ovf} !== vflg[i]) begin
        bad++; $display("FAIL vec%0d_flags got=%b exp=%b", i, {bus.zero, bus.neg, bus.ovf}, vflg[i]);
      end
`endif
      @(posedge clk); #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_back_idle got=%b exp=1", i, bus.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic to;
    bus.out_ready = 1'b0;
    do_op(64'd100, 64'd58, 1'b0, lat, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=timeout exp=valid"); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a = 64'h1111 * 64'(i + 1); bus.b = 64'h7; bus.bin = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.d !== 64'd42 || bus.bout !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=v%b d=%h b=%b exp=v1 d=2a b=0", i, bus.out_valid, bus.d, bus.bout);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=r%b v%b exp=r1 v0", bus.in_ready, bus.out_valid);
    end
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, lat, to);
    total++;
    if (to || lat != 5 || bus.d !== 64'h0 || bus.bout !== 1'b0) begin
      bad++; $display("FAIL bp_next got=lat%0d d=%h b=%b exp=lat5 d=0 b=0", lat, bus.d, bus.bout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic to;
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h0; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.d[15:0] !== 16'hFFFF) begin bad++; $display("FAIL mid_partial got=%h exp=ffff", bus.d[15:0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.d !== 64'h0 || bus.bout !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=v%b d=%h b=%b r%b exp=v0 d=0 b=0 r0", bus.out_valid, bus.d, bus.bout, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_release got=%b exp=1", bus.in_ready); end
    do_op(64'd7, 64'd3, 1'b0, lat, to);
    total++;
    if (to || lat != 5 || bus.d !== 64'd4 || bus.bout !== 1'b0) begin
      bad++; $display("FAIL mid_after got=lat%0d d=%h b=%b exp=lat5 d=4 b=0", lat, bus.d, bus.bout);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = 64'h0;
    bus.b = 64'h0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
